// File: rtl/fetch_stage.sv
// Instruction fetch: owns the 8-bit PC, addresses a combinational imem and registers word+PC into IF/ID.
// Latency: one cycle from imem_addr to if_instr; one instruction per cycle; a redirect costs one bubble.
// Backpressure: stall holds the PC and IF/ID; redirect overrides stall. Optional HLT halt: FETCH_HALT_DETECT_EN.
module fetch_stage #(
    parameter logic [7:0]  RESET_PC = 8'h00,
    parameter logic [15:0] NOP_WORD = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [7:0]  redirect_addr,
    output logic [7:0]  imem_addr,
    input  logic [15:0] imem_data,
    output logic [15:0] if_instr,
    output logic [7:0]  if_pc,
    output logic        if_valid,
    output logic        halted
);

    logic [7:0]  pc_q, pc_d;
    logic [15:0] if_instr_q, if_instr_d;
    logic [7:0]  if_pc_q, if_pc_d;
    logic        if_valid_q, if_valid_d;

`ifdef FETCH_HALT_DETECT_EN
    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic   hlt_fetched;

    // HLT is recognised on the word currently being fetched, so the halt takes effect at its capture edge.
    assign hlt_fetched = (imem_data[15:12] == 4'b1111);

    // Next-state and IF/ID update: redirect > stall > halt hold > normal fetch.
    always_comb begin
        pc_d       = pc_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        if_valid_d = if_valid_q;
        state_d    = state_q;
        if (redirect_valid) begin
            pc_d       = redirect_addr;
            if_instr_d = NOP_WORD;
            if_valid_d = 1'b0;
            state_d    = RUN;
        end else if (stall) begin
            // everything holds
        end else if (state_q == HALT) begin
            if_instr_d = NOP_WORD;
            if_valid_d = 1'b0;
        end else begin
            if_instr_d = imem_data;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            if (hlt_fetched) begin
                // PC parks on the HLT address so a later redirect is the only way out.
                state_d = HALT;
            end else begin
                pc_d = pc_q + 8'd1;
            end
        end
    end

    // State register for the RUN/HALT machine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign halted = (state_q == HALT);
`else
    // Next-state and IF/ID update: redirect > stall > normal fetch; HLT words are ordinary instructions.
    always_comb begin
        pc_d       = pc_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        if_valid_d = if_valid_q;
        if (redirect_valid) begin
            pc_d       = redirect_addr;
            if_instr_d = NOP_WORD;
            if_valid_d = 1'b0;
        end else if (!stall) begin
            if_instr_d = imem_data;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            pc_d       = pc_q + 8'd1;
        end
    end

    assign halted = 1'b0;
`endif

    // PC and IF/ID pipeline register; reset clears outputs immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            if_instr_q <= NOP_WORD;
            if_pc_q    <= 8'h00;
            if_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            if_valid_q <= if_valid_d;
        end
    end

    // imem_addr comes straight off the PC flop, with no input-to-address path.
    assign imem_addr = pc_q;
    assign if_instr  = if_instr_q;
    assign if_pc     = if_pc_q;
    assign if_valid  = if_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed stimulus with a queued scoreboard checked one step after each edge.
// Latency: expectations are tagged with the clock edge they apply to.
// Backpressure: exercises stall, redirect-over-stall, halt, PC wrap and asynchronous reset.
module tb_fetch_stage;

`ifdef FETCH_HALT_DETECT_EN
    localparam bit HD = 1'b1;
`else
    localparam bit HD = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [7:0]  redirect_addr;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic [15:0] if_instr;
    logic [7:0]  if_pc;
    logic        if_valid;
    logic        halted;
    logic        zero_rom;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          tag;
        logic [7:0]  pc;
        logic [15:0] instr;
        logic        v;
        logic        h;
        logic [7:0]  addr;
    } exp_t;

    exp_t exp_q[$];

    fetch_stage #(.RESET_PC(8'h00), .NOP_WORD(16'h0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_valid       (if_valid),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench instruction ROM.
    always_comb begin
        imem_data = 16'hF000;
        if (zero_rom) begin
            imem_data = 16'h0000;
        end else begin
            case (imem_addr)
                8'd0:                   imem_data = 16'h8442;
                8'd1, 8'd2, 8'd3:       imem_data = 16'h0000;
                8'd4:                   imem_data = 16'h88F5;
                8'd5, 8'd6, 8'd7:       imem_data = 16'h0000;
                8'd8:                   imem_data = 16'hA600;
                default:                imem_data = 16'hF000;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic rst_chk();
        chk("rst_imem_addr", 32'(imem_addr), 32'h00);
        chk("rst_if_valid",  32'(if_valid),  32'h0);
        chk("rst_if_instr",  32'(if_instr),  32'h0000);
        chk("rst_if_pc",     32'(if_pc),     32'h00);
        chk("rst_halted",    32'(halted),    32'h0);
    endtask

    // Drive inputs for the next edge at a falling edge and queue what that edge must produce.
    task automatic step(input logic st, input logic rd, input logic [7:0] ra,
                        input logic [7:0] e_pc, input logic [15:0] e_instr,
                        input logic e_v, input logic e_h, input logic [7:0] e_addr);
        exp_t e;
        stall          = st;
        redirect_valid = rd;
        redirect_addr  = ra;
        e.tag   = cyc + 1;
        e.pc    = e_pc;
        e.instr = e_instr;
        e.v     = e_v;
        e.h     = e_h;
        e.addr  = e_addr;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: just after every rising edge, compare against the expectation tagged for that edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (exp_q.size() != 0 && exp_q[0].tag == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("if_pc",     32'(if_pc),     32'(e.pc));
                chk("if_instr",  32'(if_instr),  32'(e.instr));
                chk("if_valid",  32'(if_valid),  32'(e.v));
                chk("halted",    32'(halted),    32'(e.h));
                chk("imem_addr", 32'(imem_addr), 32'(e.addr));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = 8'h00;
        zero_rom       = 1'b0;
        #2;
        rst_chk();
        @(negedge clk);
        rst_n = 1'b1;

        // Straight-line fetch of addresses 0..8.
        for (int k = 1; k <= 9; k++) begin
            logic [15:0] w;
            case (k - 1)
                0:       w = 16'h8442;
                4:       w = 16'h88F5;
                8:       w = 16'hA600;
                default: w = 16'h0000;
            endcase
            step(0, 0, 8'h00, 8'(k - 1), w, 1'b1, 1'b0, 8'(k));
        end
        // HLT at address 9.
        step(0, 0, 8'h00, 8'h09, 16'hF000, 1'b1, HD, HD ? 8'h09 : 8'h0A);
        if (HD) step(0, 0, 8'h00, 8'h09, 16'h0000, 1'b0, 1'b1, 8'h09);
        else    step(0, 0, 8'h00, 8'h0A, 16'hF000, 1'b1, 1'b0, 8'h0B);
        // Redirect out of halt to 0.
        step(0, 1, 8'h00, HD ? 8'h09 : 8'h0A, 16'h0000, 1'b0, 1'b0, 8'h00);
        step(0, 0, 8'h00, 8'h00, 16'h8442, 1'b1, 1'b0, 8'h01);
        step(0, 0, 8'h00, 8'h01, 16'h0000, 1'b1, 1'b0, 8'h02);
        step(0, 0, 8'h00, 8'h02, 16'h0000, 1'b1, 1'b0, 8'h03);
        // Two stalled cycles hold everything.
        step(1, 0, 8'h00, 8'h02, 16'h0000, 1'b1, 1'b0, 8'h03);
        step(1, 0, 8'h00, 8'h02, 16'h0000, 1'b1, 1'b0, 8'h03);
        step(0, 0, 8'h00, 8'h03, 16'h0000, 1'b1, 1'b0, 8'h04);
        // Get back to PC=2, then redirect to 4 together with stall.
        step(0, 1, 8'h00, 8'h03, 16'h0000, 1'b0, 1'b0, 8'h00);
        step(0, 0, 8'h00, 8'h00, 16'h8442, 1'b1, 1'b0, 8'h01);
        step(0, 0, 8'h00, 8'h01, 16'h0000, 1'b1, 1'b0, 8'h02);
        step(1, 1, 8'h04, 8'h01, 16'h0000, 1'b0, 1'b0, 8'h04);
        step(0, 0, 8'h00, 8'h04, 16'h88F5, 1'b1, 1'b0, 8'h05);

        // Asynchronous reset mid-cycle with PC=5.
        stall = 1'b0;
        redirect_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        rst_chk();
        zero_rom = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // Zero ROM: redirect to FE and wrap through FF to 00.
        step(0, 1, 8'hFE, 8'h00, 16'h0000, 1'b0, 1'b0, 8'hFE);
        step(0, 0, 8'h00, 8'hFE, 16'h0000, 1'b1, 1'b0, 8'hFF);
        step(0, 0, 8'h00, 8'hFF, 16'h0000, 1'b1, 1'b0, 8'h00);
        step(0, 0, 8'h00, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h01);
        step(0, 0, 8'h00, 8'h01, 16'h0000, 1'b1, 1'b0, 8'h02);

        stall          = 1'b0;
        redirect_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 16-bit CPU. It owns the 8-bit program counter, drives the address of the combinational instruction memory, and registers the returned 16-bit word plus its PC into the IF/ID pipeline register for decode. It supports decode-side stall, branch/jump redirect with a one-slot flush, and halts fetch when an HLT opcode is fetched.

## Interface

Parameters:
- `RESET_PC`, default 8'h00: PC value loaded on reset.
- `NOP_WORD`, default 16'h0000: word placed in `if_instr` on reset and on flush.

Ports (clock and reset):
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.

Ports (control and data):
- `stall`  in  1  decode cannot accept; hold the PC and the IF/ID register.
- `redirect_valid`  in  1  taken branch/jump this cycle.
- `redirect_addr`  in  8  redirect target.
- `imem_addr`  out  8  address to instruction memory; equals the PC register.
- `imem_data`  in  16  instruction word returned combinationally for `imem_addr`.
- `if_instr`  out  16  registered instruction to decode.
- `if_pc`  out  8  registered address of `if_instr`.
- `if_valid`  out  1  `if_instr` is a real fetched instruction.
- `halted`  out  1  fetch is stopped on HLT.

## Operation

- Instruction format: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm. HLT is opcode 4'b1111.
- States: RUN and HALT.
- Reset (asynchronous, `rst_n` low):
  - PC = `RESET_PC`, `if_instr` = `NOP_WORD`, `if_pc` = 8'h00.
  - `if_valid` = 0, `halted` = 0, state = RUN.
- Per-edge priority, highest first: redirect > stall > HALT hold > normal fetch.
- Redirect (any state, stall ignored):
  - PC <= `redirect_addr`; `if_instr` <= `NOP_WORD`; `if_valid` <= 0.
  - State <= RUN; `halted` <= 0.
- Stall, no redirect: PC, `if_instr`, `if_pc`, `if_valid` and state all hold.
- Normal fetch in RUN:
  - `if_instr` <= `imem_data`; `if_pc` <= PC; `if_valid` <= 1.
  - PC <= PC+1, modulo 256 (8'hFF wraps to 8'h00).
- HLT fetched in RUN (not stalled, no redirect):
  - Captured as a normal fetch with `if_valid` = 1.
  - PC does not increment and stays on the HLT address.
  - State <= HALT; `halted` <= 1 at the same edge.
- In HALT, no redirect: `if_instr` <= `NOP_WORD`, `if_valid` <= 0, PC holds, `halted` stays 1.

## Timing

- Fetch latency is one cycle: the word at `imem_addr` during cycle n appears on `if_instr` after edge n.
- Throughput is one instruction per cycle when not stalled.
- Redirect costs exactly one bubble: `if_valid` = 0 for one cycle, then the target instruction appears.
- `imem_addr` is driven directly from the PC register, with no combinational path from any input.
- Reset assertion clears all outputs immediately, not at the next edge.
- Reset deassertion is expected synchronous to `clk`.

## Configuration

- Macro `FETCH_HALT_DETECT_EN`.
- Defined: HLT detection and the HALT state behave as specified above.
- Undefined:
  - The HALT state is not built and `halted` is tied to 0.
  - HLT words pass through as ordinary instructions, with PC incrementing and `if_valid` = 1.

## Test plan

- Macro defined throughout unless stated. Bench ROM contents:
  - 0: 0x8442; 1–3: 0x0000; 4: 0x88F5.
  - 5–7: 0x0000; 8: 0xA600; others: 0xF000.
- Reset release, no stall: edges 1–9 give `if_pc` 0–8 with `if_instr` 0x8442, 0, 0, 0, 0x88F5, 0, 0, 0, 0xA600, all with `if_valid` = 1. Edge 10 gives `if_pc` = 9, `if_instr` = 0xF000, `halted` = 1. Edge 11 gives `if_valid` = 0, with `imem_addr` staying 9.
- Stall held for 2 cycles after `if_pc` = 2 is presented: `if_pc`, `if_instr`, `if_valid` and `imem_addr` (= 3) are unchanged for both cycles, and `if_pc` = 3 appears on the edge after `stall` drops.
- Redirect to 8'h04 together with `stall` while PC = 2: the next edge gives `if_valid` = 0 and `imem_addr` = 4. The edge after gives `if_instr` = 0x88F5 and `if_pc` = 4.
- While halted at 9, redirect to 8'h00: `halted` drops at that edge, and the following edge gives `if_instr` = 0x8442 with `if_valid` = 1.
- With an all-0x0000 ROM, redirect to 8'hFE: `if_pc` sequence is FE, FF, 00, 01, with no halt.
- `rst_n` pulsed low mid-cycle while PC = 5: `imem_addr` = 0, `if_valid` = 0 and `if_instr` = 0x0000 immediately, before any edge. With the macro undefined, the edge fetching address 9 gives PC = 10, `if_valid` = 1 and `halted` = 0.
